// File: rtl/pc_gen_pkg.sv
// ============================================================================
//  Module   : pc_gen_pkg
//  Brief    : Shared state encodings and defaults for the PC generator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_ST_BOOT = 2'd0,
        PC_ST_RUN  = 2'd1,
        PC_ST_HALT = 2'd2
    } pc_state_e;

    localparam int          HOLD_PC           = 1;
    localparam logic [31:0] PC_RESET_ADDR_DEF = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_gen_next.sv
// ============================================================================
//  Module   : pc_gen_next
//  Brief    : Combinational next-PC select: redirect priority mux, block
//             align and increment.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen_next import pc_gen_pkg::*; #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR_DEF),
    parameter int                FETCH_BYTES = 4,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = HOLD_PC
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              valid_i,
    input  logic              ready_i,
    input  logic              jtag_reset_flag_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    output logic              redirect_o,
    output logic              advance_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(FETCH_BYTES - 1);
    localparam logic [ADDR_W-1:0] BLK_INC   = ADDR_W'(FETCH_BYTES);

    logic [ADDR_W-1:0] w_pc_inc;

    // Aligning down first makes an unaligned redirect target land on the
    // next block boundary; overflow wraps back to address zero.
    assign w_pc_inc = (pc_i & BLK_MASK) + BLK_INC;

    always_comb begin
        redirect_o = 1'b0;
        advance_o  = 1'b0;
        next_pc_o  = pc_i;
        if (jtag_reset_flag_i) begin
            redirect_o = 1'b1;
            next_pc_o  = RESET_ADDR;
        end else if (trap_flag_i) begin
            redirect_o = 1'b1;
            next_pc_o  = trap_addr_i & WORD_MASK;
        end else if (jump_flag_i) begin
            redirect_o = 1'b1;
            next_pc_o  = jump_addr_i & WORD_MASK;
        end else if ((hold_flag_i < HOLD_W'(HOLD_PC_LVL)) && valid_i && ready_i) begin
            advance_o  = 1'b1;
            next_pc_o  = w_pc_inc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
//  Module   : pc_gen
//  Brief    : Program-counter generator with BOOT/RUN/HALT control and a
//             valid/ready fetch handshake. Optional misaligned-target check
//             compiled in with PC_GEN_MISALIGN_CHK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen import pc_gen_pkg::*; #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR_DEF),
    parameter int                FETCH_BYTES = 4,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = HOLD_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_reset_flag_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              halt_req_i,
    input  logic              resume_i,
    input  logic              pc_ready_i,
    output logic              pc_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_redirect_o,
    output logic              halted_o,
    output logic              misalign_o
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              redirect_q, redirect_d;
    logic              halted_q, halted_d;
    logic              boot_wait_q, boot_wait_d;

    logic              w_nxt_redirect;
    logic              w_nxt_advance;
    logic [ADDR_W-1:0] w_nxt_pc;

    pc_gen_next #(
        .ADDR_W      (ADDR_W),
        .RESET_ADDR  (RESET_ADDR),
        .FETCH_BYTES (FETCH_BYTES),
        .HOLD_W      (HOLD_W),
        .HOLD_PC_LVL (HOLD_PC_LVL)
    ) u_next (
        .pc_i              (pc_q),
        .valid_i           (valid_q),
        .ready_i           (pc_ready_i),
        .jtag_reset_flag_i (jtag_reset_flag_i),
        .trap_flag_i       (trap_flag_i),
        .trap_addr_i       (trap_addr_i),
        .jump_flag_i       (jump_flag_i),
        .jump_addr_i       (jump_addr_i),
        .hold_flag_i       (hold_flag_i),
        .redirect_o        (w_nxt_redirect),
        .advance_o         (w_nxt_advance),
        .next_pc_o         (w_nxt_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= PC_ST_BOOT;
            pc_q        <= RESET_ADDR;
            valid_q     <= 1'b0;
            redirect_q  <= 1'b0;
            halted_q    <= 1'b0;
            boot_wait_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            redirect_q  <= redirect_d;
            halted_q    <= halted_d;
            boot_wait_q <= boot_wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        redirect_d  = redirect_q;
        halted_d    = halted_q;
        boot_wait_d = boot_wait_q;
        case (state_q)
            PC_ST_BOOT: begin
                // First post-reset cycle is a bubble; the request appears on the second.
                if (boot_wait_q) begin
                    boot_wait_d = 1'b0;
                end else begin
                    state_d    = PC_ST_RUN;
                    pc_d       = RESET_ADDR;
                    valid_d    = 1'b1;
                    redirect_d = 1'b1;
                end
            end
            PC_ST_RUN: begin
                if (w_nxt_redirect) begin
                    pc_d       = w_nxt_pc;
                    redirect_d = 1'b1;
                end else if (halt_req_i) begin
                    state_d  = PC_ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (w_nxt_advance) begin
                    pc_d       = w_nxt_pc;
                    redirect_d = 1'b0;
                end
            end
            PC_ST_HALT: begin
                if (w_nxt_redirect) begin
                    pc_d       = w_nxt_pc;
                    redirect_d = 1'b1;
                end
                if (resume_i) begin
                    state_d  = PC_ST_RUN;
                    valid_d  = 1'b1;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = PC_ST_BOOT;
            end
        endcase
    end

`ifdef PC_GEN_MISALIGN_CHK_EN
    logic misalign_q;
    logic w_tgt_misaligned;

    // JTAG reset always targets RESET_ADDR, so only trap/jump targets are checked.
    assign w_tgt_misaligned = !jtag_reset_flag_i &&
                              (trap_flag_i ? (trap_addr_i[1:0] != 2'b00) :
                               jump_flag_i ? (jump_addr_i[1:0] != 2'b00) : 1'b0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q != PC_ST_BOOT) && w_tgt_misaligned;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc_o          = pc_q;
    assign pc_valid_o    = valid_q;
    assign pc_redirect_o = redirect_q;
    assign halted_o      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
//  Module   : tb_pc_gen
//  Brief    : Directed bench for pc_gen with 4-byte and 8-byte fetch blocks.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        jtag;
    logic        trap;
    logic [31:0] trap_addr;
    logic        jump;
    logic [31:0] jump_addr;
    logic [2:0]  hold;
    logic        halt_req;
    logic        resume;
    logic        ready;

    logic        a_valid, a_redir, a_halted, a_mis;
    logic [31:0] a_pc;
    logic        b_valid, b_redir, b_halted, b_mis;
    logic [31:0] b_pc;

    int n_checks;
    int n_pass;
    logic exp_mis;

    pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .FETCH_BYTES(4), .HOLD_W(3), .HOLD_PC_LVL(1)) u_dut_a (
        .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag),
        .trap_flag_i(trap), .trap_addr_i(trap_addr),
        .jump_flag_i(jump), .jump_addr_i(jump_addr),
        .hold_flag_i(hold), .halt_req_i(halt_req), .resume_i(resume),
        .pc_ready_i(ready), .pc_valid_o(a_valid), .pc_o(a_pc),
        .pc_redirect_o(a_redir), .halted_o(a_halted), .misalign_o(a_mis)
    );

    pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .FETCH_BYTES(8), .HOLD_W(3), .HOLD_PC_LVL(1)) u_dut_b (
        .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag),
        .trap_flag_i(trap), .trap_addr_i(trap_addr),
        .jump_flag_i(jump), .jump_addr_i(jump_addr),
        .hold_flag_i(hold), .halt_req_i(halt_req), .resume_i(resume),
        .pc_ready_i(ready), .pc_valid_o(b_valid), .pc_o(b_pc),
        .pc_redirect_o(b_redir), .halted_o(b_halted), .misalign_o(b_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        jtag      = 1'b0;
        trap      = 1'b0;
        trap_addr = 32'h0;
        jump      = 1'b0;
        jump_addr = 32'h0;
        hold      = 3'd0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        ready     = 1'b1;
`ifdef PC_GEN_MISALIGN_CHK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif

        step(); step();
        check("rst_valid",  32'(a_valid),  32'd0);
        check("rst_pc",     a_pc,          32'h0);
        check("rst_redir",  32'(a_redir),  32'd0);
        check("rst_halted", 32'(a_halted), 32'd0);
        check("rst_mis",    32'(a_mis),    32'd0);

        // Boot bubble then sequential fetch
        rst = 1'b1;
        step();
        check("boot_bubble", 32'(a_valid), 32'd0);
        step();
        check("boot_valid", 32'(a_valid), 32'd1);
        check("boot_pc",    a_pc,         32'h0);
        check("boot_redir", 32'(a_redir), 32'd1);
        step();
        check("seq_pc4",    a_pc,         32'h4);
        check("seq_redir0", 32'(a_redir), 32'd0);
        step();
        check("seq_pc8",    a_pc,         32'h8);
        check("b_seq_pc10", b_pc,         32'h10);

        // Unaligned-block jump with 8-byte blocks
        jump = 1'b1; jump_addr = 32'h104;
        step();
        jump = 1'b0;
        check("b_jmp_pc",    b_pc,         32'h104);
        check("b_jmp_redir", 32'(b_redir), 32'd1);
        step();
        check("b_jmp_pc1",   b_pc,         32'h108);
        check("a_jmp_pc1",   a_pc,         32'h108);
        step();
        check("b_jmp_pc2",   b_pc,         32'h110);
        check("a_jmp_pc2",   a_pc,         32'h10c);

        // Trap beats jump
        trap = 1'b1; trap_addr = 32'h80; jump = 1'b1; jump_addr = 32'h200;
        step();
        trap = 1'b0; jump = 1'b0;
        check("trap_prio", a_pc, 32'h80);

        // Stall at 0x20, redirect during stall
        jump = 1'b1; jump_addr = 32'h20;
        step();
        jump = 1'b0; ready = 1'b0;
        check("stall_pc0", a_pc, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",    a_pc,         32'h20);
            check("stall_valid", 32'(a_valid), 32'd1);
        end
        jump = 1'b1; jump_addr = 32'h300;
        step();
        jump = 1'b0;
        check("stall_jmp_pc",    a_pc,         32'h300);
        check("stall_jmp_redir", 32'(a_redir), 32'd1);
        step();
        check("stall_hold_pc",    a_pc,         32'h300);
        check("stall_hold_redir", 32'(a_redir), 32'd1);
        ready = 1'b1;
        step();
        check("accept_pc",    a_pc,         32'h304);
        check("accept_redir", 32'(a_redir), 32'd0);

        // Hold level blocks advance
        hold = 3'd1;
        step();
        check("hold_pc", a_pc, 32'h304);
        hold = 3'd0;
        step();
        check("unhold_pc", a_pc, 32'h308);

        // Halt, redirect while halted, resume
        halt_req = 1'b1;
        step();
        check("halt_valid",  32'(a_valid),  32'd0);
        check("halt_halted", 32'(a_halted), 32'd1);
        check("halt_pc",     a_pc,          32'h308);
        jump = 1'b1; jump_addr = 32'h40;
        step();
        jump = 1'b0;
        check("hjmp_pc",     a_pc,          32'h40);
        check("hjmp_halted", 32'(a_halted), 32'd1);
        check("hjmp_valid",  32'(a_valid),  32'd0);
        check("hjmp_redir",  32'(a_redir),  32'd1);
        halt_req = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        check("res_valid",  32'(a_valid),  32'd1);
        check("res_pc",     a_pc,          32'h40);
        check("res_redir",  32'(a_redir),  32'd1);
        check("res_halted", 32'(a_halted), 32'd0);
        step();
        check("res_next_pc", a_pc, 32'h44);

        // Halt and resume together: resume for one cycle, then re-halt
        halt_req = 1'b1;
        step();
        check("h2_halted", 32'(a_halted), 32'd1);
        check("h2_pc",     a_pc,          32'h44);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("hr_valid",  32'(a_valid),  32'd1);
        check("hr_halted", 32'(a_halted), 32'd0);
        step();
        check("hr_rehalt", 32'(a_halted), 32'd1);
        check("hr_valid0", 32'(a_valid),  32'd0);
        halt_req = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        check("hr_resume_pc", a_pc, 32'h44);

        // Misaligned jump target
        jump = 1'b1; jump_addr = 32'h1002;
        step();
        jump = 1'b0;
        check("mis_pc",    a_pc,        32'h1000);
        check("mis_pulse", 32'(a_mis),  32'(exp_mis));
        check("b_mis_pc",  b_pc,        32'h1000);
        step();
        check("mis_clear", 32'(a_mis),  32'd0);
        check("mis_next",  a_pc,        32'h1004);
        check("b_mis_next", b_pc,       32'h1008);

        // Wrap at top of memory
        jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        check("wrap_pc",   a_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_a",    a_pc, 32'h0);
        check("wrap_b",    b_pc, 32'h0);
        step();

        // JTAG reset redirect
        jtag = 1'b1;
        step();
        jtag = 1'b0;
        check("jtag_pc",    a_pc,         32'h0);
        check("jtag_redir", 32'(a_redir), 32'd1);
        check("jtag_valid", 32'(a_valid), 32'd1);
        step();
        check("jtag_next",  a_pc,         32'h4);

        // Reset mid-operation
        rst = 1'b0;
        step();
        check("mrst_valid", 32'(a_valid), 32'd0);
        check("mrst_pc",    a_pc,         32'h0);
        check("mrst_redir", 32'(a_redir), 32'd0);
        rst = 1'b1;
        step();
        check("mrst_bubble", 32'(a_valid), 32'd0);
        step();
        check("mrst_valid1", 32'(a_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
